// File: rtl/vc_pmem_arbiter_pkg.sv
// Shared types for the victim-cache / L2 physical-memory arbiter.
// Line/address typedefs, the arbiter state encoding and the last-grant marker.
package vc_pmem_arbiter_pkg;

    localparam int LC3B_LINE_ADDR_W = 12;
    localparam int LC3B_OFFSET_W    = 4;
    localparam int LC3B_LINE_W      = 128;

    typedef logic [LC3B_LINE_ADDR_W-1:0] lc3b_line_addr;
    typedef logic [LC3B_LINE_W-1:0]      lc3b_line;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_L2_RD   = 3'd1,
        ST_L2_WR   = 3'd2,
        ST_VC_WR   = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_e;

    typedef enum logic {
        GRANT_VC = 1'b0,
        GRANT_L2 = 1'b1
    } grant_e;

endpackage

// File: rtl/vc_pmem_arbiter_if.sv
// Bus bundle between L2, the victim cache, physical memory and the arbiter.
// Handshake: requests are levels held until their one-cycle resp/ack; pmem strobes are held until pmem_resp.
interface vc_pmem_arbiter_if #(
    parameter int LINE_ADDR_W = 12,
    parameter int OFFSET_W    = 4,
    parameter int LINE_W      = 128
);
    logic                            l2_pmem_read;
    logic                            l2_pmem_write;
    logic [LINE_ADDR_W-1:0]          l2_pmem_address;
    logic [LINE_W-1:0]               l2_pmem_wdata;
    logic [LINE_W-1:0]               l2_pmem_rdata;
    logic                            l2_pmem_resp;
    logic                            VC_write;
    logic [LINE_ADDR_W-1:0]          wb_address;
    logic [LINE_W-1:0]               vc_wdata;
    logic                            mem_ack;
    logic                            L2toPmem_busy;
    logic                            pmem_read;
    logic                            pmem_write;
    logic [LINE_ADDR_W+OFFSET_W-1:0] pmem_address;
    logic [LINE_W-1:0]               pmem_wdata;
    logic [LINE_W-1:0]               pmem_rdata;
    logic                            pmem_resp;

    modport slave (
        input  l2_pmem_read, l2_pmem_write, l2_pmem_address, l2_pmem_wdata,
        input  VC_write, wb_address, vc_wdata,
        input  pmem_rdata, pmem_resp,
        output l2_pmem_rdata, l2_pmem_resp, mem_ack, L2toPmem_busy,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output l2_pmem_read, l2_pmem_write, l2_pmem_address, l2_pmem_wdata,
        output VC_write, wb_address, vc_wdata,
        output pmem_rdata, pmem_resp,
        input  l2_pmem_rdata, l2_pmem_resp, mem_ack, L2toPmem_busy,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/vc_pmem_arbiter_pmem_req_reg.sv
// Holding register for one pmem request: line address, write data and direction.
// Loads on load_i and otherwise keeps its contents for the whole transaction.
module vc_pmem_arbiter_pmem_req_reg #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              write_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              write_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              write_q, write_d;

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        write_d = write_q;
        if (load_i) begin
            addr_d  = addr_i;
            data_d  = data_i;
            write_d = write_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            write_q <= write_d;
        end
    end

    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign write_o = write_q;

endmodule

// File: rtl/vc_pmem_arbiter.sv
// Arbitrates physical memory between L2 fills/writebacks and victim-cache writebacks.
// One transaction at a time; strobes come from registered state, acks pulse the cycle after pmem_resp.
module vc_pmem_arbiter
    import vc_pmem_arbiter_pkg::*;
#(
    parameter int LINE_ADDR_W = 12,
    parameter int OFFSET_W    = 4,
    parameter int LINE_W      = 128
) (
    input  logic               clk,
    input  logic               rst,
    vc_pmem_arbiter_if.slave   bus,
    output arb_state_e         dbg_state
);

    arb_state_e             state_q, state_d;
    grant_e                 last_grant_q, last_grant_d;
    logic                   l2_resp_q, l2_resp_d;
    logic                   mem_ack_q, mem_ack_d;
    logic [LINE_W-1:0]      rdata_q, rdata_d;

    logic                   req_load;
    logic [LINE_ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0]      req_data;
    logic                   req_write;
    logic [LINE_ADDR_W-1:0] held_addr;
    logic [LINE_W-1:0]      held_data;
    logic                   held_write;

    logic l2_req;
    logic vc_first;
    logic active;

    assign l2_req = bus.l2_pmem_read | bus.l2_pmem_write;

    // VC goes first on a same-line read (no stale fill) or when L2 had the last grant (no starvation).
    assign vc_first = bus.VC_write &
                      (~l2_req |
                       (bus.l2_pmem_read & (bus.l2_pmem_address == bus.wb_address)) |
                       (last_grant_q == GRANT_L2));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        l2_resp_d    = 1'b0;
        mem_ack_d    = 1'b0;
        rdata_d      = rdata_q;
        req_load     = 1'b0;
        req_addr     = bus.l2_pmem_address;
        req_data     = bus.l2_pmem_wdata;
        req_write    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vc_first) begin
                    state_d      = ST_VC_WR;
                    last_grant_d = GRANT_VC;
                    req_load     = 1'b1;
                    req_addr     = bus.wb_address;
                    req_data     = bus.vc_wdata;
                    req_write    = 1'b1;
                end else if (bus.l2_pmem_read) begin
                    state_d      = ST_L2_RD;
                    last_grant_d = GRANT_L2;
                    req_load     = 1'b1;
                end else if (bus.l2_pmem_write) begin
                    state_d      = ST_L2_WR;
                    last_grant_d = GRANT_L2;
                    req_load     = 1'b1;
                    req_write    = 1'b1;
                end
            end
            ST_L2_RD: begin
                if (bus.pmem_resp) begin
                    rdata_d   = bus.pmem_rdata;
                    l2_resp_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_L2_WR: begin
                if (bus.pmem_resp) begin
                    l2_resp_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_VC_WR: begin
                if (bus.pmem_resp) begin
                    mem_ack_d = 1'b1;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_VC;
            l2_resp_q    <= 1'b0;
            mem_ack_q    <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            l2_resp_q    <= l2_resp_d;
            mem_ack_q    <= mem_ack_d;
            rdata_q      <= rdata_d;
        end
    end

    vc_pmem_arbiter_pmem_req_reg #(
        .ADDR_W (LINE_ADDR_W),
        .DATA_W (LINE_W)
    ) u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (req_load),
        .addr_i  (req_addr),
        .data_i  (req_data),
        .write_i (req_write),
        .addr_o  (held_addr),
        .data_o  (held_data),
        .write_o (held_write)
    );

    assign active = (state_q == ST_L2_RD) | (state_q == ST_L2_WR) | (state_q == ST_VC_WR);

    assign bus.pmem_read     = active & ~held_write;
    assign bus.pmem_write    = active & held_write;
    assign bus.pmem_address  = {held_addr, {OFFSET_W{1'b0}}};
    assign bus.pmem_wdata    = held_data;
    assign bus.l2_pmem_rdata = rdata_q;
    assign bus.l2_pmem_resp  = l2_resp_q;
    assign bus.mem_ack       = mem_ack_q;
    assign bus.L2toPmem_busy = (state_q == ST_L2_RD) | (state_q == ST_L2_WR) |
                               ((state_q == ST_IDLE) & l2_req);
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_vc_pmem_arbiter.sv
// Self-checking bench for vc_pmem_arbiter: expected pmem transactions queue up as requests are driven
// and are popped when a strobe appears; acks, busy and state are checked around each transaction.
module tb_vc_pmem_arbiter;
  import vc_pmem_arbiter_pkg::*;

  localparam int AW    = 12;
  localparam int OW    = 4;
  localparam int LW    = 128;
  localparam int TXN_W = 2 + AW + OW + LW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vc_pmem_arbiter_if #(.LINE_ADDR_W(AW), .OFFSET_W(OW), .LINE_W(LW)) bus ();
  arb_state_e dbg_state;

  vc_pmem_arbiter #(.LINE_ADDR_W(AW), .OFFSET_W(OW), .LINE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [TXN_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TXN_W-1:0] mk_txn(input logic wr, input lc3b_line_addr a, input lc3b_line d);
    return {~wr, wr, a, {OW{1'b0}}, (wr ? d : {LW{1'b0}})};
  endfunction

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_l2(input logic rd, input logic wr, input lc3b_line_addr a, input lc3b_line d);
    bus.l2_pmem_read    = rd;
    bus.l2_pmem_write   = wr;
    bus.l2_pmem_address = a;
    bus.l2_pmem_wdata   = d;
  endtask

  task automatic drive_vc(input logic v, input lc3b_line_addr a, input lc3b_line d);
    bus.VC_write   = v;
    bus.wb_address = a;
    bus.vc_wdata   = d;
  endtask

  // Acts as memory: waits for a strobe, scores it, holds for delay cycles, then pulses pmem_resp.
  // Returns at the negedge of the cycle after pmem_resp (the ack cycle).
  task automatic serve(input int delay, input lc3b_line rd);
    logic [TXN_W-1:0] obs;
    int waited;
    waited = 0;
    while (!(bus.pmem_read || bus.pmem_write) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!(bus.pmem_read || bus.pmem_write)) begin
      check("strobe_timeout", {159'd0, (bus.pmem_read | bus.pmem_write)}, 160'd1);
      return;
    end
    obs = {bus.pmem_read, bus.pmem_write, bus.pmem_address,
           (bus.pmem_write ? bus.pmem_wdata : {LW{1'b0}})};
    if (exp_q.size() == 0) check("unexpected_txn", obs, '0);
    else check("pmem_txn", obs, exp_q.pop_front());
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("strobe_held", {bus.pmem_read, bus.pmem_write}, obs[TXN_W-1 -: 2]);
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = rd;
    @(negedge clk);
    bus.pmem_resp  = 1'b0;
  endtask

  task automatic check_ack(input string tag, input logic l2_exp, input logic vc_exp);
    check({tag, "_l2_resp"}, bus.l2_pmem_resp, l2_exp);
    check({tag, "_mem_ack"}, bus.mem_ack, vc_exp);
    check({tag, "_state"}, dbg_state, ST_RELEASE);
  endtask

  lc3b_line rd_data;
  lc3b_line d1, d2;

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_l2(0, 0, '0, '0);
    drive_vc(0, '0, '0);
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    do_reset();

    // reset state
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
    check("rst_addr", bus.pmem_address, '0);
    check("rst_wdata", bus.pmem_wdata, '0);
    check("rst_rdata", bus.l2_pmem_rdata, '0);
    check("rst_acks", {bus.l2_pmem_resp, bus.mem_ack, bus.L2toPmem_busy}, 3'b000);

    // L2 read alone, pmem_resp after 5 cycles
    rd_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    drive_l2(1, 0, 12'h123, '0);
    exp_q.push_back(mk_txn(0, 12'h123, '0));
    #1 check("t1_busy_idle", bus.L2toPmem_busy, 1'b1);
    @(negedge clk);
    check("t1_strobe_latency", bus.pmem_read, 1'b1);
    check("t1_busy_rd", bus.L2toPmem_busy, 1'b1);
    serve(5, rd_data);
    check_ack("t1", 1'b1, 1'b0);
    check("t1_rdata", bus.l2_pmem_rdata, rd_data);
    drive_l2(0, 0, '0, '0);
    @(negedge clk);
    check("t1_resp_one_cycle", {bus.l2_pmem_resp, bus.mem_ack}, 2'b00);
    check("t1_idle", dbg_state, ST_IDLE);

    // VC + L2 read on different lines, last_grant=VC: L2 first, then VC despite a new L2 read
    do_reset();
    d1 = {4{32'hA0A0_0001}};
    drive_vc(1, 12'h0A0, d1);
    drive_l2(1, 0, 12'h0B1, '0);
    exp_q.push_back(mk_txn(0, 12'h0B1, '0));
    exp_q.push_back(mk_txn(1, 12'h0A0, d1));
    exp_q.push_back(mk_txn(0, 12'h0C2, '0));
    serve(2, {4{32'h0B10_0B10}});
    check_ack("t2a", 1'b1, 1'b0);
    drive_l2(1, 0, 12'h0C2, '0);
    serve(1, '0);
    check_ack("t2b", 1'b0, 1'b1);
    drive_vc(0, '0, '0);
    serve(0, {4{32'h0C20_0C20}});
    check_ack("t2c", 1'b1, 1'b0);
    check("t2_rdata", bus.l2_pmem_rdata, {4{32'h0C20_0C20}});
    drive_l2(0, 0, '0, '0);
    @(negedge clk);

    // VC and L2 read on the same line: writeback before fill
    do_reset();
    d1 = {4{32'h5A5A_0A00}};
    drive_vc(1, 12'h0A0, d1);
    drive_l2(1, 0, 12'h0A0, '0);
    exp_q.push_back(mk_txn(1, 12'h0A0, d1));
    exp_q.push_back(mk_txn(0, 12'h0A0, '0));
    serve(3, '0);
    check_ack("t3a", 1'b0, 1'b1);
    drive_vc(0, '0, '0);
    serve(2, d1);
    check_ack("t3b", 1'b1, 1'b0);
    check("t3_fill_sees_wb", bus.l2_pmem_rdata, d1);
    drive_l2(0, 0, '0, '0);
    @(negedge clk);

    // VC only: busy stays low; VC_write held past the ack cycle must not re-grant
    do_reset();
    d2 = {4{32'hC0FF_EE00}};
    drive_vc(1, 12'h3F0, d2);
    exp_q.push_back(mk_txn(1, 12'h3F0, d2));
    #1 check("t4_busy_idle", bus.L2toPmem_busy, 1'b0);
    @(negedge clk);
    check("t4_busy_vc", bus.L2toPmem_busy, 1'b0);
    serve(2, '0);
    check_ack("t4", 1'b0, 1'b1);
    check("t4_busy_rel", bus.L2toPmem_busy, 1'b0);
    @(negedge clk);
    drive_vc(0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      check("t4_no_second_write", {bus.pmem_write, bus.mem_ack, bus.L2toPmem_busy}, 3'b000);
      @(negedge clk);
    end
    check("t4_idle", dbg_state, ST_IDLE);

    // rst two cycles into L2_WR
    drive_l2(0, 1, 12'h055, {4{32'h5555_AAAA}});
    @(negedge clk);
    check("t5_wr_strobe", bus.pmem_write, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_strobe_drop", {bus.pmem_read, bus.pmem_write}, 2'b00);
    check("t5_state", dbg_state, ST_IDLE);
    check("t5_addr_clr", bus.pmem_address, '0);
    drive_l2(0, 0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check("t5_no_resp", {bus.l2_pmem_resp, bus.mem_ack}, 2'b00);
    check("t5_ignore_resp", dbg_state, ST_IDLE);
    @(negedge clk);
    check("t5_still_idle", {bus.pmem_read, bus.pmem_write, bus.l2_pmem_resp}, 3'b000);

    // back-to-back L2 writes, one RELEASE between them
    d1 = {4{32'h0100_1111}};
    d2 = {4{32'h0110_2222}};
    drive_l2(0, 1, 12'h010, d1);
    exp_q.push_back(mk_txn(1, 12'h010, d1));
    exp_q.push_back(mk_txn(1, 12'h011, d2));
    serve(1, '0);
    check_ack("t6a", 1'b1, 1'b0);
    drive_l2(0, 1, 12'h011, d2);
    @(negedge clk);
    check("t6_gap_idle", dbg_state, ST_IDLE);
    serve(0, '0);
    check_ack("t6b", 1'b1, 1'b0);
    drive_l2(0, 0, '0, '0);
    @(negedge clk);

    // illegal L2 read+write together: read wins
    drive_l2(1, 1, 12'h3C3, {4{32'hFFFF_0000}});
    exp_q.push_back(mk_txn(0, 12'h3C3, '0));
    serve(1, {4{32'h3C3C_3C3C}});
    check_ack("t7", 1'b1, 1'b0);
    drive_l2(0, 0, '0, '0);
    @(negedge clk);

    // random single-requester traffic
    for (int i = 0; i < 8; i++) begin
      int kind;
      lc3b_line_addr a;
      lc3b_line d;
      kind = $urandom_range(0, 2);
      a    = lc3b_line_addr'($urandom_range(0, 4095));
      d    = {$urandom, $urandom, $urandom, $urandom};
      rd_data = {$urandom, $urandom, $urandom, $urandom};
      if (kind == 2) begin
        drive_vc(1, a, d);
        exp_q.push_back(mk_txn(1, a, d));
      end else begin
        drive_l2(kind == 0, kind == 1, a, d);
        exp_q.push_back(mk_txn(kind == 1, a, d));
      end
      serve($urandom_range(0, 4), rd_data);
      check_ack("rnd", kind != 2, kind == 2);
      if (kind == 0) check("rnd_rdata", bus.l2_pmem_rdata, rd_data);
      drive_l2(0, 0, '0, '0);
      drive_vc(0, '0, '0);
      @(negedge clk);
    end

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
